// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, multi-cycle EX, taken-branch squash and data-memory wait.
// Optional performance counters are built in when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic              dec_use_rs1,
   input  logic              dec_use_rs2,
   input  logic              ex_valid,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_multi,
   input  logic              br_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              ifdec_en,
   output logic              ifdec_flush,
   output logic              decex_en,
   output logic              decex_bubble,
   output logic              exmem_en,
   output logic              exmem_bubble,
   output logic              busy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count
`endif
);

   localparam int CNT_W = $clog2(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);

   typedef enum logic {RUN = 1'b0, MULWAIT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frz;
   logic             lu;

   assign frz = mem_req & ~mem_ready;
   assign lu  = ex_valid & ex_mem_read & (ex_rd != '0) &
                ((dec_use_rs1 & (dec_rs1 == ex_rd)) | (dec_use_rs2 & (dec_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_en        = 1'b0;
      ifdec_en     = 1'b0;
      ifdec_flush  = 1'b0;
      decex_en     = 1'b0;
      decex_bubble = 1'b0;
      exmem_en     = 1'b0;
      exmem_bubble = 1'b0;
      busy         = 1'b1;

      if (rst) begin
         state_d = RUN;
         cnt_d   = '0;
      end else if (!frz) begin
         case (state_q)
            RUN: begin
               busy = 1'b0;
               if (ex_valid && br_taken) begin
                  // Squash the two younger instructions; the branch itself moves on.
                  pc_en        = 1'b1;
                  ifdec_en     = 1'b1;
                  ifdec_flush  = 1'b1;
                  decex_en     = 1'b1;
                  decex_bubble = 1'b1;
                  exmem_en     = 1'b1;
               end else if (ex_valid && ex_multi) begin
                  // busy covers the whole multi-cycle occupancy, entry cycle included.
                  exmem_en     = 1'b1;
                  exmem_bubble = 1'b1;
                  busy         = 1'b1;
                  state_d      = MULWAIT;
                  cnt_d        = CNT_INIT;
               end else if (lu) begin
                  decex_en     = 1'b1;
                  decex_bubble = 1'b1;
                  exmem_en     = 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifdec_en = 1'b1;
                  decex_en = 1'b1;
                  exmem_en = 1'b1;
               end
            end
            MULWAIT: begin
               if (cnt_q != '0) begin
                  exmem_en     = 1'b1;
                  exmem_bubble = 1'b1;
                  cnt_d        = cnt_q - 1'b1;
               end else begin
                  pc_en    = 1'b1;
                  ifdec_en = 1'b1;
                  decex_en = 1'b1;
                  exmem_en = 1'b1;
                  state_d  = RUN;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_q, flush_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_en)      stall_q <= sat_inc(stall_q);
         if (ifdec_flush) flush_q <= sat_inc(flush_q);
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; define PIPE_PERF_CNT_EN to also check the perf counters.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW  = 5;
   localparam int MUL_LAT = 3;

   // Output vector order: pc_en, ifdec_en, ifdec_flush, decex_en, decex_bubble, exmem_en, exmem_bubble, busy
   localparam logic [7:0] O_RUN   = 8'b1101_0100;
   localparam logic [7:0] O_LU    = 8'b0001_1100;
   localparam logic [7:0] O_BR    = 8'b1111_1100;
   localparam logic [7:0] O_MUL   = 8'b0000_0111;
   localparam logic [7:0] O_REL   = 8'b1101_0101;
   localparam logic [7:0] O_HOLD  = 8'b0000_0001;

   logic              clk = 1'b0;
   logic              rst;
   logic [REG_AW-1:0] dec_rs1, dec_rs2, ex_rd;
   logic              dec_use_rs1, dec_use_rs2, ex_valid, ex_mem_read, ex_multi;
   logic              br_taken, mem_req, mem_ready;
   logic              pc_en, ifdec_en, ifdec_flush, decex_en, decex_bubble;
   logic              exmem_en, exmem_bubble, busy;
   logic [7:0]        outs;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]       stall_cycles, flush_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_multi(ex_multi), .br_taken(br_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifdec_en(ifdec_en), .ifdec_flush(ifdec_flush),
      .decex_en(decex_en), .decex_bubble(decex_bubble),
      .exmem_en(exmem_en), .exmem_bubble(exmem_bubble), .busy(busy)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   assign outs = {pc_en, ifdec_en, ifdec_flush, decex_en, decex_bubble, exmem_en, exmem_bubble, busy};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; dec_rs1 = '0; dec_rs2 = '0; ex_rd = '0;
      dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
      ex_multi = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      idle(); rst = 1'b1;
      step(); #1 chk("reset_outs", 32'(outs), 32'(O_HOLD));
      step(); #1 chk("reset_outs2", 32'(outs), 32'(O_HOLD));
      step(); idle(); #1 chk("run_idle", 32'(outs), 32'(O_RUN));

      // Load-use on rs1: one stall cycle, then normal flow.
      step(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; dec_rs1 = 5'd5; dec_use_rs1 = 1;
      #1 chk("lu_rs1_stall", 32'(outs), 32'(O_LU));
      step(); ex_valid = 0; ex_mem_read = 0;
      #1 chk("lu_after", 32'(outs), 32'(O_RUN));

      // Load to x0 and an unused matching rs2 must not stall; a used rs2 match must.
      step(); idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd0; dec_rs1 = 5'd0; dec_use_rs1 = 1;
      #1 chk("lu_x0", 32'(outs), 32'(O_RUN));
      step(); idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; dec_rs2 = 5'd7;
      #1 chk("lu_rs2_unused", 32'(outs), 32'(O_RUN));
      dec_use_rs2 = 1;
      #1 chk("lu_rs2_used", 32'(outs), 32'(O_LU));
      mem_req = 1;
      #1 chk("frz_over_lu", 32'(outs), 32'(O_HOLD));

      // Reset pulse clears the perf counters before the multi-cycle case.
      step(); idle(); rst = 1;
      #1 chk("rst_pulse", 32'(outs), 32'(O_HOLD));

      // Multi-cycle op, MUL_LAT=3: two stall cycles then release.
      step(); idle(); ex_valid = 1; ex_multi = 1;
      #1 chk("mul_entry", 32'(outs), 32'(O_MUL));
      step(); #1 chk("mul_wait", 32'(outs), 32'(O_MUL));
      step(); #1 chk("mul_release", 32'(outs), 32'(O_REL));
      step(); idle(); #1 chk("mul_run", 32'(outs), 32'(O_RUN));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall_mul", stall_cycles, 32'd2);
      chk("perf_flush_zero", flush_count, 32'd0);
`endif

      // Branch wins over a simultaneous load-use; no stall afterwards.
      step(); ex_valid = 1; br_taken = 1; ex_mem_read = 1; ex_rd = 5'd5; dec_rs1 = 5'd5; dec_use_rs1 = 1;
      #1 chk("br_over_lu", 32'(outs), 32'(O_BR));
      step(); idle(); #1 chk("br_after", 32'(outs), 32'(O_RUN));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_flush_one", flush_count, 32'd1);
`endif

      // Freeze in MULWAIT with cnt=1 holds for 4 cycles, then 1 stall and release.
      step(); ex_valid = 1; ex_multi = 1;
      #1 chk("mulf_entry", 32'(outs), 32'(O_MUL));
      for (int i = 0; i < 4; i++) begin
         step(); mem_req = 1; mem_ready = 0;
         #1 chk("mulf_frz", 32'(outs), 32'(O_HOLD));
      end
      step(); mem_ready = 1;
      #1 chk("mulf_stall", 32'(outs), 32'(O_MUL));
      step(); mem_req = 0; mem_ready = 0;
      #1 chk("mulf_release", 32'(outs), 32'(O_REL));
      step(); idle(); #1 chk("mulf_run", 32'(outs), 32'(O_RUN));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall_frz", stall_cycles, 32'd8);
`endif

      // Branch held in EX during a freeze acts once the freeze clears.
      step(); ex_valid = 1; br_taken = 1; mem_req = 1;
      #1 chk("br_frz", 32'(outs), 32'(O_HOLD));
      step(); mem_ready = 1;
      #1 chk("br_after_frz", 32'(outs), 32'(O_BR));

      // Reset mid-MULWAIT aborts the op.
      step(); idle(); ex_valid = 1; ex_multi = 1;
      #1 chk("abort_entry", 32'(outs), 32'(O_MUL));
      step(); rst = 1;
      #1 chk("abort_rst", 32'(outs), 32'(O_HOLD));
      step(); idle(); #1 chk("abort_run", 32'(outs), 32'(O_RUN));
`ifdef PIPE_PERF_CNT_EN
      chk("perf_stall_cleared", stall_cycles, 32'd0);
      chk("perf_flush_cleared", flush_count, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
